// File: rtl/axi_lite_calc_master_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_calc_master_if
// Description : AXI4-Lite bus between the calculator master and its slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_lite_calc_master_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_calc_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_calc_master
// Description : Writes op1/op2/opcode to slave offsets 0..2, reads the result
//               at offset 3 and returns it with a status code.
//               Optional macro CALC_TIMEOUT_EN adds a per-phase watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_calc_master #(
    parameter int unsigned           DATA_WIDTH     = 8,
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned           TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [DATA_WIDTH-1:0]  cmd_op1,
    input  logic [DATA_WIDTH-1:0]  cmd_op2,
    input  logic [DATA_WIDTH-1:0]  cmd_opcode,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_data,
    output logic [1:0]             rsp_err,
    axi_lite_calc_master_if.master bus
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_AW   = 3'd1;
    localparam logic [2:0] c_ST_W    = 3'd2;
    localparam logic [2:0] c_ST_B    = 3'd3;
    localparam logic [2:0] c_ST_AR   = 3'd4;
    localparam logic [2:0] c_ST_R    = 3'd5;
    localparam logic [2:0] c_ST_RSP  = 3'd6;

    localparam logic [1:0] c_ERR_OK  = 2'b00;
    localparam logic [1:0] c_ERR_SLV = 2'b10;
    localparam logic [1:0] c_ERR_TMO = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] c_RD_ADDR = BASE_ADDR + ADDR_WIDTH'(3);

    logic [2:0]            r_state,     w_state_nxt;
    logic [1:0]            r_idx,       w_idx_nxt;
    logic [DATA_WIDTH-1:0] r_op1,       w_op1_nxt;
    logic [DATA_WIDTH-1:0] r_op2,       w_op2_nxt;
    logic [DATA_WIDTH-1:0] r_opc,       w_opc_nxt;
    logic                  r_cmd_ready, w_cmd_ready_nxt;
    logic                  r_awvalid,   w_awvalid_nxt;
    logic [ADDR_WIDTH-1:0] r_awaddr,    w_awaddr_nxt;
    logic                  r_wvalid,    w_wvalid_nxt;
    logic [DATA_WIDTH-1:0] r_wdata,     w_wdata_nxt;
    logic                  r_bready,    w_bready_nxt;
    logic                  r_arvalid,   w_arvalid_nxt;
    logic [ADDR_WIDTH-1:0] r_araddr,    w_araddr_nxt;
    logic                  r_rready,    w_rready_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] r_rsp_data,  w_rsp_data_nxt;
    logic [1:0]            r_err,       w_err_nxt;

    logic [DATA_WIDTH-1:0] w_wsel;
    logic [1:0]            w_idx_inc;
    logic                  w_tmo_hit;

    assign w_wsel    = (r_idx == 2'd0) ? r_op1 : (r_idx == 2'd1) ? r_op2 : r_opc;
    assign w_idx_inc = r_idx + 2'd1;

`ifdef CALC_TIMEOUT_EN
    localparam int unsigned c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               w_in_axi;

    assign w_in_axi  = r_state inside {c_ST_AW, c_ST_W, c_ST_B, c_ST_AR, c_ST_R};
    assign w_tmo_hit = w_in_axi && (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));

    // Restarts on every state change so each bus phase gets its own budget.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tmo_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_tmo_cnt <= '0;
        end else if (w_in_axi) begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
    assign w_tmo_hit    = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_op1_nxt       = r_op1;
        w_op2_nxt       = r_op2;
        w_opc_nxt       = r_opc;
        w_cmd_ready_nxt = r_cmd_ready;
        w_awvalid_nxt   = r_awvalid;
        w_awaddr_nxt    = r_awaddr;
        w_wvalid_nxt    = r_wvalid;
        w_wdata_nxt     = r_wdata;
        w_bready_nxt    = r_bready;
        w_arvalid_nxt   = r_arvalid;
        w_araddr_nxt    = r_araddr;
        w_rready_nxt    = r_rready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
        w_err_nxt       = r_err;

        case (r_state)
            c_ST_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_op1_nxt       = cmd_op1;
                    w_op2_nxt       = cmd_op2;
                    w_opc_nxt       = cmd_opcode;
                    w_cmd_ready_nxt = 1'b0;
                    w_state_nxt     = c_ST_AW;
                end
            end
            c_ST_AW: begin
                // Entry from IDLE arrives with awvalid low; later writes enter with it set.
                if (!r_awvalid) begin
                    w_awvalid_nxt = 1'b1;
                    w_awaddr_nxt  = BASE_ADDR + ADDR_WIDTH'(r_idx);
                end else if (bus.awready) begin
                    w_awvalid_nxt = 1'b0;
                    w_wvalid_nxt  = 1'b1;
                    w_wdata_nxt   = w_wsel;
                    w_state_nxt   = c_ST_W;
                end
            end
            c_ST_W: begin
                if (bus.wready) begin
                    w_wvalid_nxt = 1'b0;
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = c_ST_B;
                end
            end
            c_ST_B: begin
                if (bus.bvalid) begin
                    w_bready_nxt = 1'b0;
                    if ((bus.bresp != 2'b00) && (r_err == c_ERR_OK)) begin
                        w_err_nxt = c_ERR_SLV;
                    end
                    if (r_idx < 2'd2) begin
                        w_idx_nxt     = w_idx_inc;
                        w_awvalid_nxt = 1'b1;
                        w_awaddr_nxt  = BASE_ADDR + ADDR_WIDTH'(w_idx_inc);
                        w_state_nxt   = c_ST_AW;
                    end else begin
                        w_arvalid_nxt = 1'b1;
                        w_araddr_nxt  = c_RD_ADDR;
                        w_state_nxt   = c_ST_AR;
                    end
                end
            end
            c_ST_AR: begin
                if (bus.arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = c_ST_R;
                end
            end
            c_ST_R: begin
                if (bus.rvalid) begin
                    w_rsp_data_nxt  = bus.rdata;
                    w_rready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = c_ST_RSP;
                    if ((bus.rresp != 2'b00) && (r_err == c_ERR_OK)) begin
                        w_err_nxt = c_ERR_SLV;
                    end
                end
            end
            c_ST_RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_err_nxt       = c_ERR_OK;
                    w_idx_nxt       = 2'd0;
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        // Watchdog expiry abandons the phase and reports a timeout with no data.
        if (w_tmo_hit && (w_state_nxt == r_state)) begin
            w_awvalid_nxt   = 1'b0;
            w_wvalid_nxt    = 1'b0;
            w_bready_nxt    = 1'b0;
            w_arvalid_nxt   = 1'b0;
            w_rready_nxt    = 1'b0;
            w_rsp_data_nxt  = '0;
            w_err_nxt       = c_ERR_TMO;
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = c_ST_RSP;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= c_ST_IDLE;
            r_idx       <= 2'd0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_opc       <= '0;
            r_cmd_ready <= 1'b1;
            r_awvalid   <= 1'b0;
            r_awaddr    <= '0;
            r_wvalid    <= 1'b0;
            r_wdata     <= '0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_err       <= c_ERR_OK;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_op1       <= w_op1_nxt;
            r_op2       <= w_op2_nxt;
            r_opc       <= w_opc_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_awaddr    <= w_awaddr_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_wdata     <= w_wdata_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_araddr    <= w_araddr_nxt;
            r_rready    <= w_rready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_err;
    assign bus.awvalid = r_awvalid;
    assign bus.awaddr  = r_awaddr;
    assign bus.wvalid  = r_wvalid;
    assign bus.wdata   = r_wdata;
    assign bus.bready  = r_bready;
    assign bus.arvalid = r_arvalid;
    assign bus.araddr  = r_araddr;
    assign bus.rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_calc_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_calc_master
// Description : Self-checking bench with a reactive calculator slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_calc_master;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 32;

    logic          clk        = 1'b0;
    logic          rstn       = 1'b0;
    logic          cmd_valid  = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] cmd_op1    = '0;
    logic [DW-1:0] cmd_op2    = '0;
    logic [DW-1:0] cmd_opcode = '0;
    logic          rsp_valid;
    logic          rsp_ready  = 1'b1;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    axi_lite_calc_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axi_lite_calc_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(32'h0), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_opcode(cmd_opcode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] calc(input logic [DW-1:0] a, b, op);
        case (op)
            8'd0:    calc = a + b;
            8'd1:    calc = a - b;
            8'd2:    calc = a & b;
            default: calc = a ^ b;
        endcase
    endfunction

    // ---------------- slave model ----------------
    int         aw_delay = 0;
    int         r_delay  = 0;
    int         berr_at  = -1;
    int         sl_wcnt  = 0;
    logic       w_block  = 1'b0;
    logic       sl_awready;
    int         sl_awcnt;
    logic [1:0] sl_waddr;
    logic [7:0] sl_regs [0:2];
    logic       sl_rpend;
    int         sl_rcnt;

    assign bus.awready = (aw_delay == 0) ? 1'b1 : sl_awready;
    assign bus.wready  = ~w_block;
    assign bus.arready = 1'b1;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sl_awready <= 1'b0; sl_awcnt <= 0; sl_waddr <= 2'd0;
            bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
            bus.rvalid <= 1'b0; bus.rdata <= '0; bus.rresp <= 2'b00;
            sl_rpend   <= 1'b0; sl_rcnt <= 0;
        end else begin
            if (bus.awvalid && bus.awready) begin
                sl_waddr   <= bus.awaddr[1:0];
                sl_awready <= 1'b0;
                sl_awcnt   <= 0;
            end else if (bus.awvalid) begin
                if (sl_awcnt + 1 >= aw_delay) sl_awready <= 1'b1;
                sl_awcnt <= sl_awcnt + 1;
            end
            if (bus.wvalid && bus.wready) begin
                if (sl_waddr != 2'd3) sl_regs[sl_waddr] <= bus.wdata;
                bus.bvalid <= 1'b1;
                bus.bresp  <= (sl_wcnt == berr_at) ? 2'b10 : 2'b00;
                sl_wcnt    <= sl_wcnt + 1;
            end else if (bus.bvalid && bus.bready) begin
                bus.bvalid <= 1'b0;
            end
            if (bus.arvalid && bus.arready) begin
                if (r_delay == 0) begin
                    bus.rvalid <= 1'b1;
                    bus.rdata  <= calc(sl_regs[0], sl_regs[1], sl_regs[2]);
                end else begin
                    sl_rpend <= 1'b1;
                    sl_rcnt  <= r_delay - 1;
                end
            end else if (sl_rpend) begin
                if (sl_rcnt == 0) begin
                    sl_rpend   <= 1'b0;
                    bus.rvalid <= 1'b1;
                    bus.rdata  <= calc(sl_regs[0], sl_regs[1], sl_regs[2]);
                end else begin
                    sl_rcnt <= sl_rcnt - 1;
                end
            end else if (bus.rvalid && bus.rready) begin
                bus.rvalid <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [31:0] exp_aw[$];
    logic [7:0]  exp_w[$];
    logic [31:0] exp_ar[$];
    logic [9:0]  exp_rsp[$];

    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, rsp_cnt = 0;
    int rsp_rise_cyc = 0, rsp_hs_cyc = 0, rdy_rise_cyc = 0, aw_fall_cyc = 0;
    logic hold_chk_en = 1'b1;

    logic        p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs, p_rspv, p_rsphs, p_cmdr;
    logic [31:0] p_awaddr, p_araddr;
    logic [7:0]  p_wdata, p_rdata;
    logic [1:0]  p_rerr;

    always @(negedge clk) begin
        if (rstn) begin
            chk("one_channel", 32'(($countones({bus.awvalid, bus.wvalid, bus.bready,
                                                bus.arvalid, bus.rready}) <= 1)), 32'd1);
            if (hold_chk_en && p_awv && !p_awhs) begin
                chk("awvalid_hold", 32'(bus.awvalid), 32'd1);
                chk("awaddr_hold", bus.awaddr, p_awaddr);
            end
            if (p_awv && !p_awhs && !bus.awvalid) aw_fall_cyc = cyc;
            if (p_wv && !p_whs) begin
                chk("wvalid_hold", 32'(bus.wvalid), 32'd1);
                chk("wdata_hold", 32'(bus.wdata), 32'(p_wdata));
            end
            if (p_arv && !p_arhs) chk("araddr_hold", bus.araddr, p_araddr);
            if (p_rspv && !p_rsphs) begin
                chk("rsp_valid_hold", 32'(rsp_valid), 32'd1);
                chk("rsp_hold", 32'({rsp_err, rsp_data}), 32'({p_rerr, p_rdata}));
            end
            if (rsp_valid && !p_rspv) rsp_rise_cyc = cyc;
            if (cmd_ready && !p_cmdr) rdy_rise_cyc = cyc;

            if (bus.awvalid && bus.awready) begin
                aw_hs++;
                chk("aw_expected", 32'(exp_aw.size() > 0), 32'd1);
                if (exp_aw.size() > 0) chk("awaddr", bus.awaddr, exp_aw.pop_front());
            end
            if (bus.wvalid && bus.wready) begin
                w_hs++;
                chk("w_expected", 32'(exp_w.size() > 0), 32'd1);
                if (exp_w.size() > 0) chk("wdata", 32'(bus.wdata), 32'(exp_w.pop_front()));
            end
            if (bus.bvalid && bus.bready) b_hs++;
            if (bus.arvalid && bus.arready) begin
                ar_hs++;
                chk("ar_expected", 32'(exp_ar.size() > 0), 32'd1);
                if (exp_ar.size() > 0) chk("araddr", bus.araddr, exp_ar.pop_front());
            end
            if (bus.rvalid && bus.rready) r_hs++;
            if (rsp_valid && rsp_ready) begin
                rsp_cnt++;
                rsp_hs_cyc = cyc;
                chk("rsp_expected", 32'(exp_rsp.size() > 0), 32'd1);
                if (exp_rsp.size() > 0)
                    chk("rsp_err_data", 32'({rsp_err, rsp_data}), 32'(exp_rsp.pop_front()));
            end

            p_awv = bus.awvalid; p_awhs = bus.awvalid && bus.awready; p_awaddr = bus.awaddr;
            p_wv  = bus.wvalid;  p_whs  = bus.wvalid && bus.wready;   p_wdata  = bus.wdata;
            p_arv = bus.arvalid; p_arhs = bus.arvalid && bus.arready; p_araddr = bus.araddr;
            p_rspv = rsp_valid;  p_rsphs = rsp_valid && rsp_ready;
            p_rdata = rsp_data;  p_rerr = rsp_err;
            p_cmdr = cmd_ready;
        end else begin
            p_awv = 1'b0; p_awhs = 1'b0; p_wv = 1'b0; p_whs = 1'b0;
            p_arv = 1'b0; p_arhs = 1'b0; p_rspv = 1'b0; p_rsphs = 1'b0;
            p_cmdr = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic flush();
        exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_rsp.delete();
    endtask

    task automatic send_cmd(input logic [7:0] a, b, op, input logic [1:0] e, output int hs);
        for (int i = 0; i < 3; i++) exp_aw.push_back(32'(i));
        exp_w.push_back(a); exp_w.push_back(b); exp_w.push_back(op);
        exp_ar.push_back(32'd3);
        exp_rsp.push_back({e, calc(a, b, op)});
        cmd_op1 = a; cmd_op2 = b; cmd_opcode = op; cmd_valid = 1'b1;
        hs = -1;
        for (int t = 0; t < 300; t++) begin
            if (cmd_ready) begin
                @(posedge clk); #1;
                hs = cyc;
                break;
            end
            @(negedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk("cmd_accepted", 32'(hs >= 0), 32'd1);
    endtask

    task automatic wait_rsp(input int target);
        for (int t = 0; t < 400 && rsp_cnt < target; t++) begin
            @(negedge clk); #1;
        end
        chk("rsp_arrived", 32'(rsp_cnt >= target), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, hs2, n_rsp, b_aw, b_w, b_b, b_ar, b_r;
        n_rsp = 0;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_valids", 32'({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid,
                               bus.rready, rsp_valid}), 32'd0);
        chk("rst_awaddr", bus.awaddr, 32'd0);
        chk("rst_araddr", bus.araddr, 32'd0);
        chk("rst_wdata_rsp", 32'({bus.wdata, rsp_data, rsp_err}), 32'd0);
        rstn = 1'b1;
        @(negedge clk); #1;

        // T1: immediate slave, latency
        b_aw = aw_hs; b_w = w_hs; b_b = b_hs; b_ar = ar_hs; b_r = r_hs;
        send_cmd(8'd2, 8'd3, 8'd0, 2'b00, hs);
        n_rsp++; wait_rsp(n_rsp);
        chk("t1_latency", 32'(rsp_rise_cyc - hs), 32'd12);
        chk("t1_hs_counts", 32'({8'(aw_hs - b_aw), 8'(w_hs - b_w), 8'(b_hs - b_b),
                                 4'(ar_hs - b_ar), 4'(r_hs - b_r)}),
            {8'd3, 8'd3, 8'd3, 4'd1, 4'd1});

        // T2: delayed awready and rvalid
        aw_delay = 5; r_delay = 3;
        @(negedge clk); #1;
        b_aw = aw_hs; b_w = w_hs; b_b = b_hs; b_ar = ar_hs; b_r = r_hs;
        send_cmd(8'd2, 8'd3, 8'd0, 2'b00, hs);
        n_rsp++; wait_rsp(n_rsp);
        chk("t2_hs_counts", 32'({8'(aw_hs - b_aw), 8'(w_hs - b_w), 8'(b_hs - b_b),
                                 4'(ar_hs - b_ar), 4'(r_hs - b_r)}),
            {8'd3, 8'd3, 8'd3, 4'd1, 4'd1});
        chk("t2_slow_latency", 32'(rsp_rise_cyc - hs > 12), 32'd1);
        aw_delay = 0; r_delay = 0;

        // T3: slave error on the second write
        @(negedge clk); #1;
        berr_at = sl_wcnt + 1;
        b_ar = ar_hs;
        send_cmd(8'd12, 8'd5, 8'd1, 2'b10, hs);
        n_rsp++; wait_rsp(n_rsp);
        chk("t3_read_done", 32'(ar_hs - b_ar), 32'd1);
        berr_at = -1;

        // T4: reset asserted while W of index 1 is stalled
        @(negedge clk); #1;
        b_aw = aw_hs;
        send_cmd(8'd4, 8'd6, 8'd2, 2'b00, hs);
        for (int t = 0; t < 100 && (aw_hs - b_aw) < 2; t++) begin
            @(negedge clk); #1;
        end
        chk("t4_second_aw", 32'(aw_hs - b_aw), 32'd2);
        w_block = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        chk("t4_w_stalled", 32'({bus.wvalid, bus.wdata}), {23'd0, 1'b1, 8'd6});
        rstn = 1'b0;
        #1;
        chk("t4_async_wvalid", 32'(bus.wvalid), 32'd0);
        chk("t4_async_ready", 32'({cmd_ready, bus.awvalid, bus.bready, rsp_valid}), 32'b1000);
        chk("t4_async_wdata", 32'(bus.wdata), 32'd0);
        flush();
        w_block = 1'b0;
        @(negedge clk); #1;
        rstn = 1'b1;
        @(negedge clk); #1;
        send_cmd(8'd7, 8'd1, 8'd0, 2'b00, hs);
        n_rsp++; wait_rsp(n_rsp);

        // T5: back-to-back, error flag must not leak into the second response
        @(negedge clk); #1;
        berr_at = sl_wcnt;
        send_cmd(8'd2, 8'd3, 8'd0, 2'b10, hs);
        send_cmd(8'd9, 8'd4, 8'd1, 2'b00, hs2);
        chk("t5_ready_rise", 32'(rdy_rise_cyc), 32'(rsp_hs_cyc + 1));
        chk("t5_second_hs", 32'(hs2), 32'(rsp_hs_cyc + 2));
        n_rsp += 2; wait_rsp(n_rsp);
        berr_at = -1;

`ifdef CALC_TIMEOUT_EN
        // T6: awready never arrives
        @(negedge clk); #1;
        aw_delay = 100000; hold_chk_en = 1'b0;
        send_cmd(8'd2, 8'd3, 8'd0, 2'b11, hs);
        exp_rsp.delete(); exp_rsp.push_back({2'b11, 8'h00});
        n_rsp++; wait_rsp(n_rsp);
        chk("t6_aw_drop", 32'(aw_fall_cyc - hs), 32'd16);
        flush();
        aw_delay = 0; hold_chk_en = 1'b1;
`endif

        repeat (3) @(negedge clk);
        chk("final_queues_empty", 32'(exp_aw.size() + exp_w.size() + exp_ar.size()
                                      + exp_rsp.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
